// File: rtl/conv_pkg.sv
// conv_pkg: shared state/mode encodings and accumulator width helper for the convolution core.
package conv_pkg;
    typedef enum logic [2:0] {S_IDLE, S_JLOOP, S_MAC, S_WRITE, S_DONE} state_t;
    typedef enum logic {MODE_FULL = 1'b0, MODE_VALID = 1'b1} mode_t;

    function automatic int acc_w(input int data_w, input int addr_w);
        return 2 * data_w + addr_w;
    endfunction
endpackage

// File: rtl/convolution_coprocesor_core_mac.sv
// conv_mac: signed multiply-accumulate register with synchronous clear and enable.
module conv_mac #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 21
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic signed [ACC_W-1:0]  acc
);
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;

    assign prod     = a * b;
    assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};

    always_ff @(posedge clk or posedge rst)
        if (rst) acc <= '0;
        else if (clr) acc <= '0;
        else if (en) acc <= acc + prod_ext;
endmodule

// File: rtl/convolution_coprocesor_core.sv
// convolution_coprocesor_core: 1-D signed convolution engine (FULL/VALID) driving X/H reads and Z writes.
module convolution_coprocesor_core
    import conv_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5,
    parameter int ACC_W  = acc_w(DATA_W, ADDR_W)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     mode,
    input  logic [ADDR_W-1:0]        size_x,
    input  logic [ADDR_W-1:0]        size_h,
    output logic [ADDR_W-1:0]        x_addr,
    output logic                     x_rd,
    input  logic signed [DATA_W-1:0] x_rdata,
    output logic [ADDR_W-1:0]        h_addr,
    output logic                     h_rd,
    input  logic signed [DATA_W-1:0] h_rdata,
    output logic [ADDR_W:0]          z_addr,
    output logic                     z_we,
    output logic signed [ACC_W-1:0]  z_wdata,
    output logic                     busy,
    output logic                     done,
    output logic                     error
);
    localparam int IW = ADDR_W + 1;
    localparam int KW = ADDR_W + 2;

    state_t                   state, next;
    mode_t                    mode_r;
    logic [ADDR_W-1:0]        nx, nh, j;
    logic [IW-1:0]            i, first, last;
    logic signed [KW-1:0]     kh;
    logic                     in_rng, bad_cfg, rd, err_r;
    logic signed [ACC_W-1:0]  acc;

    assign bad_cfg = size_x == '0 || size_h == '0 || (mode && size_h > size_x);
    assign first   = mode_r == MODE_VALID ? {1'b0, nh} - IW'(1) : '0;
    assign last    = mode_r == MODE_VALID ? {1'b0, nx} - IW'(1) : {1'b0, nx} + {1'b0, nh} - IW'(2);
    assign kh      = $signed({1'b0, i}) - $signed({2'b0, j});
    assign in_rng  = !kh[KW-1] && kh[KW-2:0] < {1'b0, nh};
    assign rd      = state == S_JLOOP && j != nx && in_rng;

    assign x_rd    = rd;
    assign h_rd    = rd;
    assign x_addr  = rd ? j : '0;
    assign h_addr  = rd ? kh[ADDR_W-1:0] : '0;
    assign z_we    = state == S_WRITE;
    assign z_addr  = z_we ? i - first : '0;
    assign z_wdata = z_we ? acc : '0;
    assign busy    = state != S_IDLE;
    assign done    = state == S_DONE;
    assign error   = err_r;

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= S_IDLE;
        else state <= next;

    always_comb begin
        next = state;
        case (state)
            S_IDLE:  next = start ? (bad_cfg ? S_DONE : S_JLOOP) : S_IDLE;
            S_JLOOP: next = j == nx ? S_WRITE : (in_rng ? S_MAC : S_JLOOP);
            S_MAC:   next = S_JLOOP;
            S_WRITE: next = i == last ? S_DONE : S_JLOOP;
            S_DONE:  next = S_IDLE;
            default: next = S_IDLE;
        endcase
    end

    // first output index is derived from the incoming size, since nh is not yet latched
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            mode_r <= MODE_FULL;
            nx     <= '0;
            nh     <= '0;
            i      <= '0;
            j      <= '0;
            err_r  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    mode_r <= mode_t'(mode);
                    nx     <= size_x;
                    nh     <= size_h;
                    err_r  <= bad_cfg;
                    i      <= mode ? {1'b0, size_h} - IW'(1) : '0;
                    j      <= '0;
                end
                S_JLOOP: if (j != nx && !in_rng) j <= j + 1'b1;
                S_MAC:   j <= j + 1'b1;
                S_WRITE: if (i != last) begin
                    i <= i + 1'b1;
                    j <= '0;
                end
                default: ;
            endcase
        end

    conv_mac #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_mac (
        .clk (clk),
        .rst (rst),
        .clr (state == S_WRITE || (state == S_IDLE && start)),
        .en  (state == S_MAC),
        .a   (x_rdata),
        .b   (h_rdata),
        .acc (acc)
    );
endmodule
